dec2hex: RTL
============

// Module: dec2hex
// PURPOSE
// - Converts a packed-BCD value (data_dec_t style, 4 bits per decimal digit, MS digit at MSB) to plain binary.
// - Inverse of the hex2dec packing stage; sits between decimal-formatted results and the binary datapath of mxv.
// - Iterative digit-serial multiply-accumulate (acc = acc*10 + digit), one digit per clock.
// - Valid/ready handshake on both sides.
// PARAMETERS
// - DIGITS  2  number of BCD digits in dec_i (>=1)
// - BIN_W   7  width of hex_o; must satisfy 2**BIN_W >= 10**DIGITS
// PORTS
// - clk        in   1          clock, all logic on rising edge
// - rst        in   1          synchronous, active-high reset
// - in_valid   in   1          dec_i valid
// - in_ready   out  1          converter idle, can accept
// - dec_i      in   4*DIGITS   packed BCD input, digit d at bits [4d+3:4d]
// - out_valid  out  1          hex_o (and err_o) valid
// - out_ready  in   1          downstream accepts result
// - hex_o      out  BIN_W      binary result
// - err_o      out  1          invalid-digit flag (only with DEC2HEX_ERR_EN)
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): state=IDLE, acc=0, cnt=0, shadow reg=0, hex_o=0, out_valid=0, err_o=0.
//   in_ready is forced 0 while rst=1. Reset mid-conversion aborts it; no result is produced.
// - FSM states: IDLE, CONV, DONE.
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch dec_i into the shadow reg, acc<=0, cnt<=DIGITS-1, go to CONV.
//   - CONV: in_ready=0. Each cycle: acc<=acc*10+digit[cnt], then cnt<=cnt-1.
//     When cnt==0 (last digit) go to DONE.
//   - DONE: out_valid=1, hex_o=acc. Hold hex_o/err_o stable until out_ready=1.
//     On out_valid&&out_ready go to IDLE.
// - Latency: for an accept edge k, out_valid rises after edge k+DIGITS.
//   The next accept is possible at the first edge after the output handshake.
//   No same-cycle output/input overlap: minimum period is DIGITS+2 cycles.
// - dec_i changes after acceptance have no effect (shadow reg used).
// - in_valid while busy is ignored (in_ready=0); the upstream must hold it.
// - Arithmetic: acc*10 computed as (acc<<3)+(acc<<1) in BIN_W+4 bits.
//   The result is truncated to BIN_W bits (modulo 2**BIN_W) each step.
// - Digit values 10..15 are weighted as their binary value (e.g. 0xA5 -> 10*10+5=105).
//   Wrap applies if the result exceeds BIN_W (0xFF -> 165 mod 128 = 37).
// - out_ready=1 with out_valid=0 has no effect; out_ready is sampled only in DONE.
// CONFIGURATION
// - DEC2HEX_ERR_EN defined: err_o port exists.
//   - err accumulates: set if any digit >9 during CONV, cleared on accept.
//   - err_o = err in DONE, else 0. hex_o is still computed as above.
// - DEC2HEX_ERR_EN undefined: no err_o port and no error logic; invalid digits are converted silently.
// TESTING
// - Reset: rst=1 for 2 cycles -> in_ready=0, out_valid=0, hex_o=0; after release in_ready=1 next cycle.
// - dec_i=8'h42 accepted, out_ready=1 -> out_valid exactly 2 cycles after accept, hex_o=7'd42, in_ready back 1 cycle later.
// - dec_i=8'h99 with out_ready=0 for 5 cycles -> hex_o=99 held stable, in_ready=0 throughout; released on out_ready=1.
// - In-flight: accept 8'h17, change dec_i to 8'h55 and pulse in_valid during CONV -> hex_o=17; 8'h55 not accepted until IDLE.
// - Reset mid-op: accept 8'h63, rst=1 at edge k+1 -> no out_valid; after release, accept 8'h05 -> hex_o=5.
// - DEC2HEX_ERR_EN: dec_i=8'h1A -> hex_o=20, err_o=1; next dec_i=8'h08 -> hex_o=8, err_o=0.
//   Without the macro, dec_i=8'h1A -> hex_o=20.

Source files
------------

// File: rtl/dec2hex_if.sv
// Valid/ready bundle for the dec2hex packed-BCD to binary converter.
// err_o exists only when DEC2HEX_ERR_EN is defined.
interface dec2hex_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   dec_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      hex_o;
`ifdef DEC2HEX_ERR_EN
    logic                  err_o;
`endif

    modport master (
        output in_valid,
        output dec_i,
        output out_ready,
`ifdef DEC2HEX_ERR_EN
        input  err_o,
`endif
        input  in_ready,
        input  out_valid,
        input  hex_o
    );

    modport slave (
        input  in_valid,
        input  dec_i,
        input  out_ready,
`ifdef DEC2HEX_ERR_EN
        output err_o,
`endif
        output in_ready,
        output out_valid,
        output hex_o
    );
endinterface

// File: rtl/dec2hex.sv
// Digit-serial packed-BCD to binary converter: acc = acc*10 + digit, MS digit first.
// Optional invalid-digit flag on err_o when DEC2HEX_ERR_EN is defined.
module dec2hex #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic       clk,
    input  logic       rst,
    dec2hex_if.slave   bus
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DEC_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [DEC_W-1:0]    shadow;
    logic [BIN_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          digit;
    logic [BIN_W+3:0]    acc_wide;
    logic [BIN_W+3:0]    acc_x10;
    logic [BIN_W-1:0]    acc_step;
    logic [3:0]          unused_hi;
    logic                in_ready;
    logic                out_valid;

    // The shadow register shifts left each step, so the current digit is always on top.
    assign digit    = shadow[DEC_W-1 -: 4];
    assign acc_wide = {4'b0000, acc};
    assign acc_x10  = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, digit};
    assign {unused_hi, acc_step} = acc_x10;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shadow <= bus.dec_i;
                        acc    <= '0;
                        cnt    <= CNT_W'(DIGITS - 1);
                    end
                end
                CONV: begin
                    acc    <= acc_step;
                    shadow <= shadow << 4;
                    cnt    <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef DEC2HEX_ERR_EN
    logic err;

    // Sticky over one conversion; cleared again when the next operand is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            err <= 1'b0;
        end else if (state == CONV && digit > 4'd9) begin
            err <= 1'b1;
        end
    end

    assign bus.err_o = (state == DONE) && err;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.hex_o     = acc;
endmodule
